// File: rtl/conv_in_streamer_pkg.sv
// Shared types and sizing helpers for the conv input streamer.
package conv_in_streamer_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Beat width: CONV_UNITS outputs plus one halo word on each side.
    function automatic int unsigned beat_w(input int unsigned conv_units,
                                           input int unsigned data_width);
        return (conv_units + 2) * data_width;
    endfunction

endpackage

// File: rtl/conv_in_streamer_stream_fifo2.sv
// Two-entry valid/ready FIFO with registered storage and occupancy count.
module stream_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] w_data,
    output logic             r_valid,
    input  logic             r_rdy,
    output logic [WIDTH-1:0] r_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign r_valid = (count_q != 2'd0);
    assign r_data  = rd_ptr_q ? mem1_q : mem0_q;
    assign count   = count_q;
    assign pop     = r_valid & r_rdy;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_valid) begin
            if (wr_ptr_q) mem1_d = w_data;
            else          mem0_d = w_data;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = 2'(count_q + 2'(w_valid) - 2'(pop));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/conv_in_streamer.sv
// Streams one frame of image beats from a 1-cycle BRAM port into a valid/ready channel.
module conv_in_streamer
    import conv_in_streamer_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned CONV_UNITS = 8,
    parameter  int unsigned ADDR_WIDTH = 16,
    localparam int unsigned BEAT_W     = beat_w(CONV_UNITS, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  mode,
    input  logic [CNT_W-1:0]      ch_in,
    input  logic [CNT_W-1:0]      im_width,
    input  logic [CNT_W-1:0]      num_blocks,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BEAT_W-1:0]     mem_rdata,
    output logic                  r_valid,
    input  logic                  r_rdy,
    output logic [BEAT_W-1:0]     r_data,
    output logic                  r_last,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [CNT_W-1:0]      ch_q, ch_d;
    logic [CNT_W-1:0]      iw_q, iw_d;
    logic [CNT_W-1:0]      nb_q, nb_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      c_q, c_d;
    logic [CNT_W-1:0]      w_q, w_d;
    logic [CNT_W-1:0]      b_q, b_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic                  last_c, last_w, last_b;
    logic                  issue, pop;
    logic [2:0]            occ;
    logic [1:0]            fifo_count;
    logic                  fifo_r_valid;
    logic [BEAT_W:0]       fifo_r_data;
    logic [BEAT_W:0]       fifo_w_data;
    logic [BEAT_W-1:0]     beat_masked;

    assign last_c = (c_q == ch_q - 32'd1);
    assign last_w = (w_q == iw_q - 32'd1);
    assign last_b = (b_q == nb_q - 32'd1);
    assign pop    = fifo_r_valid & r_rdy;
    assign occ    = 3'(fifo_count) + 3'(inflight_q);

    // A new read may only launch if its data is guaranteed a FIFO slot on arrival.
    assign issue  = (state_q == ST_FETCH) && ((occ - 3'(pop)) < 3'd2);

    assign mem_en   = issue;
    assign mem_addr = addr_q;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign r_valid  = fifo_r_valid;
    assign r_data   = fifo_r_data[BEAT_W-1:0];
    assign r_last   = fifo_r_data[BEAT_W];

    // 1x1 mode drops the halo words on the way into the FIFO.
    always_comb begin
        beat_masked = mem_rdata;
        if (mode_q) begin
            beat_masked[DATA_WIDTH-1:0]        = '0;
            beat_masked[BEAT_W-1 -: DATA_WIDTH] = '0;
        end
    end
    assign fifo_w_data = {inflight_last_q, beat_masked};

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        ch_d            = ch_q;
        iw_d            = iw_q;
        nb_d            = nb_q;
        addr_d          = addr_q;
        c_d             = c_q;
        w_d             = w_q;
        b_d             = b_q;
        inflight_d      = issue;
        inflight_last_d = issue & last_c & last_w;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    ch_d   = ch_in;
                    iw_d   = im_width;
                    nb_d   = num_blocks;
                    addr_d = base_addr;
                    c_d    = '0;
                    w_d    = '0;
                    b_d    = '0;
                    if ((ch_in == '0) || (im_width == '0) || (num_blocks == '0))
                        state_d = ST_DONE;
                    else
                        state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (last_c) begin
                        c_d = '0;
                        if (last_w) begin
                            w_d = '0;
                            if (last_b) state_d = ST_DRAIN;
                            else        b_d = b_q + 32'd1;
                        end else begin
                            w_d = w_q + 32'd1;
                        end
                    end else begin
                        c_d = c_q + 32'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_count == 2'd1) && pop) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            mode_q          <= 1'b0;
            ch_q            <= '0;
            iw_q            <= '0;
            nb_q            <= '0;
            addr_q          <= '0;
            c_q             <= '0;
            w_q             <= '0;
            b_q             <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            ch_q            <= ch_d;
            iw_q            <= iw_d;
            nb_q            <= nb_d;
            addr_q          <= addr_d;
            c_q             <= c_d;
            w_q             <= w_d;
            b_q             <= b_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    stream_fifo2 #(
        .WIDTH (BEAT_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .w_valid (inflight_q),
        .w_data  (fifo_w_data),
        .r_valid (fifo_r_valid),
        .r_rdy   (r_rdy),
        .r_data  (fifo_r_data),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_conv_in_streamer.sv
// Directed bench for conv_in_streamer: table of frame configs plus latency/start/reset sequences.
module tb_conv_in_streamer;

    localparam int unsigned DW = 16;
    localparam int unsigned CU = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned BW = (CU + 2) * DW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          mode;
    logic [31:0]   ch_in, im_width, num_blocks;
    logic [AW-1:0] base_addr;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_rdata;
    logic          r_valid;
    logic          r_rdy;
    logic [BW-1:0] r_data;
    logic          r_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          mode;
        int unsigned   ch;
        int unsigned   iw;
        int unsigned   nb;
        logic [AW-1:0] base;
        logic          rand_rdy;
        int unsigned   exp_beats;
    } vec_t;

    vec_t          vecs[7];
    logic [BW:0]   exp_q[$];

    always #5 clk = ~clk;

    conv_in_streamer #(
        .DATA_WIDTH (DW),
        .CONV_UNITS (CU),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .mode       (mode),
        .ch_in      (ch_in),
        .im_width   (im_width),
        .num_blocks (num_blocks),
        .base_addr  (base_addr),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .r_valid    (r_valid),
        .r_rdy      (r_rdy),
        .r_data     (r_data),
        .r_last     (r_last),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [BW-1:0] bram_word(input logic [AW-1:0] a);
        logic [BW-1:0] d;
        for (int i = 0; i < int'(CU + 2); i++) d[i*DW +: DW] = {a[11:0], 4'(i)};
        return d;
    endfunction

    // BRAM model: one-cycle read latency.
    always @(posedge clk) if (mem_en) mem_rdata <= bram_word(mem_addr);

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic build_exp(input vec_t v);
        int unsigned   idx;
        logic [BW-1:0] d;
        logic [AW-1:0] a;
        exp_q.delete();
        idx = 0;
        for (int unsigned b = 0; b < v.nb; b++)
            for (int unsigned w = 0; w < v.iw; w++)
                for (int unsigned c = 0; c < v.ch; c++) begin
                    a = AW'(v.base + AW'(idx));
                    d = bram_word(a);
                    if (v.mode) begin
                        d[DW-1:0]      = '0;
                        d[BW-1 -: DW] = '0;
                    end
                    exp_q.push_back({(c == v.ch - 1) && (w == v.iw - 1), d});
                    idx++;
                end
    endtask

    task automatic run_frame(input vec_t v);
        int  idx, cyc, last_acc, n_en;
        bit  done_seen;
        bit  zero;
        build_exp(v);
        zero = (v.ch == 0) || (v.iw == 0) || (v.nb == 0);
        @(negedge clk);
        mode = v.mode; ch_in = v.ch; im_width = v.iw; num_blocks = v.nb;
        base_addr = v.base; start = 1'b1; r_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; last_acc = -1; n_en = 0; done_seen = 0;
        while (cyc < 2000 && !done_seen) begin
            r_rdy = v.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 0) chk("busy_first", busy, !zero);
            if (mem_en) n_en++;
            if (r_valid) begin
                if (idx < exp_q.size()) chk("beat", {r_last, r_data}, exp_q[idx]);
                else chk("beat_overrun", idx, exp_q.size());
                if (r_rdy) begin
                    idx++;
                    last_acc = cyc;
                end
            end
            if (done) begin
                done_seen = 1;
                if (!zero) chk("done_gap", cyc - last_acc, 1);
                else       chk("zero_done_at", cyc, 0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", done_seen, 1);
        chk("beat_count", idx, v.exp_beats);
        chk("mem_en_count", n_en, v.exp_beats);
        @(negedge clk);
        #1;
        chk("done_one_cycle", {done, busy, r_valid}, 3'b000);
    endtask

    initial begin
        int acc;
        vec_t hv;

        vecs[0] = '{1'b0, 3, 4, 2, 16'h0010, 1'b0, 24};
        vecs[1] = '{1'b0, 3, 4, 2, 16'h0010, 1'b1, 24};
        vecs[2] = '{1'b1, 1, 2, 1, 16'h0040, 1'b0, 2};
        vecs[3] = '{1'b0, 2, 3, 0, 16'h0000, 1'b0, 0};
        vecs[4] = '{1'b0, 2, 2, 1, 16'hFFFE, 1'b1, 4};
        vecs[5] = '{1'b0, 0, 5, 5, 16'h0200, 1'b0, 0};
        vecs[6] = '{1'b0, 1, 1, 1, 16'h0005, 1'b0, 1};

        rstn = 1'b0; start = 1'b0; mode = 1'b0; ch_in = '0; im_width = '0;
        num_blocks = '0; base_addr = '0; r_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", {mem_en, mem_addr, r_valid, r_last, busy, done}, '0);
        chk("reset_data", r_data, '0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Latency, start-while-busy and start-on-done sequence.
        hv = '{1'b0, 1, 1, 3, 16'h0100, 1'b0, 3};
        build_exp(hv);
        @(negedge clk);
        mode = 1'b0; ch_in = 1; im_width = 1; num_blocks = 3; base_addr = 16'h0100;
        start = 1'b1; r_rdy = 1'b1;
        @(negedge clk);
        #1;
        chk("lat_k1", {mem_en, busy, r_valid, mem_addr}, {3'b110, 16'h0100});
        ch_in = 7; base_addr = 16'h0999;
        @(negedge clk);
        #1;
        chk("lat_k2_rvalid", r_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("lat_k3_beat", {r_valid, r_last, r_data}, {1'b1, exp_q[0]});
        start = 1'b0;
        acc = 1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            #1;
            if (r_valid && r_rdy) acc++;
        end
        chk("busy_start_ignored_beats", acc, 3);
        chk("done_reached", done, 1'b1);
        start = 1'b1;
        @(negedge clk);
        #1;
        chk("start_on_done_ignored", {busy, mem_en, done}, 3'b000);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("still_idle", {busy, mem_en}, 2'b00);

        // Reset abort after the fifth beat.
        @(negedge clk);
        mode = 1'b0; ch_in = 3; im_width = 4; num_blocks = 2; base_addr = 16'h0010;
        start = 1'b1; r_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 100 && acc < 5; c++) begin
            #1;
            if (r_valid && r_rdy) acc++;
            @(negedge clk);
        end
        chk("abort_reached_beat5", acc, 5);
        chk("abort_pre_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("abort_outs", {mem_en, mem_addr, r_valid, r_last, busy, done}, '0);
        chk("abort_data", r_data, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", {done, busy}, 2'b00);
        end
        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
